// File: rtl/par_serial_tx.sv
// Parallel-to-serial symbol transmitter: sends IDLE_SYM during an initial sync
// run and whenever no byte is pending, otherwise sends accepted bytes MSB first.
module par_serial_tx #(
  parameter logic [7:0]  IDLE_SYM = 8'hBC,
  parameter int unsigned SYNC_CNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       sym_is_data,
  output logic       byte_start
);

  localparam int unsigned SymW = 8;
  localparam int unsigned BitW = 3;
  localparam int unsigned SynW = 4;

  typedef enum logic {
    ST_SYNC,
    ST_ACTIVE
  } state_e;

  state_e            state_q, state_d;
  logic [SymW-1:0]   shreg_q, shreg_d;
  logic [SymW-1:0]   hold_q, hold_d;
  logic              full_q, full_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SynW-1:0]   sync_cnt_q, sync_cnt_d;
  logic              sym_q, sym_d;
  logic              ready_q, ready_d;
  logic              bstart_q, bstart_d;
  logic              boundary_c;
  logic              xfer_c;

  assign boundary_c  = (bit_cnt_q == BitW'(7));
  assign xfer_c      = valid_in && ready_q;

  assign data_out    = shreg_q[SymW-1];
  assign ready_out   = ready_q;
  assign sym_is_data = sym_q;
  assign byte_start  = bstart_q;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SYNC;
      shreg_q    <= IDLE_SYM;
      hold_q     <= '0;
      full_q     <= 1'b0;
      bit_cnt_q  <= '0;
      sync_cnt_q <= '0;
      sym_q      <= 1'b0;
      ready_q    <= 1'b0;
      bstart_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      sym_q      <= sym_d;
      ready_q    <= ready_d;
      bstart_q   <= bstart_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = {shreg_q[SymW-2:0], 1'b0};
    hold_d     = hold_q;
    full_d     = full_q;
    bit_cnt_d  = BitW'(bit_cnt_q + BitW'(1));
    sync_cnt_d = sync_cnt_q;
    sym_d      = sym_q;

    // Symbol boundary: pending byte wins over the idle symbol once active.
    if (boundary_c) begin
      if (full_q && (state_q == ST_ACTIVE)) begin
        shreg_d = hold_q;
        full_d  = 1'b0;
        sym_d   = 1'b1;
      end else begin
        shreg_d = IDLE_SYM;
        sym_d   = 1'b0;
      end
      if (state_q == ST_SYNC) begin
        sync_cnt_d = SynW'(sync_cnt_q + SynW'(1));
        if (sync_cnt_q == SynW'(SYNC_CNT - 1)) begin
          state_d = ST_ACTIVE;
        end
      end
    end

    // ready_q is low whenever hold is full, so this never collides with the unload.
    if (xfer_c) begin
      hold_d = data_in;
      full_d = 1'b1;
    end

    ready_d  = (state_d == ST_ACTIVE) && !full_d;
    bstart_d = (bit_cnt_d == BitW'(0));
  end

endmodule

// File: tb/tb_par_serial_tx.sv
// Directed self-checking bench for par_serial_tx: sync run, single and
// back-to-back bytes, boundary transfer, mid-symbol reset, SYNC_CNT=1.
module tb_par_serial_tx;

  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk_32f;
  logic       reset, reset1;
  logic [7:0] data_in, data_in1;
  logic       valid_in, valid_in1;
  logic       ready_out, data_out, sym_is_data, byte_start;
  logic       ready_out1, data_out1, sym_is_data1, byte_start1;

  int n_chk;
  int n_pass;
  int edge_n;

  par_serial_tx #(.IDLE_SYM(8'hBC), .SYNC_CNT(4)) u_dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .sym_is_data(sym_is_data),
    .byte_start (byte_start)
  );

  par_serial_tx #(.IDLE_SYM(8'hBC), .SYNC_CNT(1)) u_dut1 (
    .clk_32f    (clk_32f),
    .reset      (reset1),
    .data_in    (data_in1),
    .valid_in   (valid_in1),
    .ready_out  (ready_out1),
    .data_out   (data_out1),
    .sym_is_data(sym_is_data1),
    .byte_start (byte_start1)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic bit_of(input logic [7:0] b, input int n);
    return b[7 - (n % 8)];
  endfunction

  task automatic tick();
    @(posedge clk_32f);
    @(negedge clk_32f);
    edge_n++;
  endtask

  task automatic check_reset_outs();
    check("rst_data_out", 32'(data_out), 32'(1));
    check("rst_byte_start", 32'(byte_start), 32'(1));
    check("rst_sym", 32'(sym_is_data), 32'(0));
    check("rst_ready", 32'(ready_out), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    valid_in = 1'b0;
    data_in  = 8'h00;
    reset    = 1'b1;
    #1;
    check_reset_outs();
    @(negedge clk_32f);
    reset  = 1'b0;
    edge_n = 0;
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) tick();
  endtask

  logic [7:0] seq [3];

  initial begin
    n_chk = 0; n_pass = 0; edge_n = 0;
    reset = 1'b1; reset1 = 1'b1;
    valid_in = 1'b0; data_in = 8'h00;
    valid_in1 = 1'b0; data_in1 = 8'h00;
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03;

    // Sync run with valid_in low: idle pattern, byte_start cadence, ready timing.
    do_reset();
    for (int n = 1; n <= 32; n++) begin
      tick();
      check("sync_data_out", 32'(data_out), 32'(bit_of(IDLE, n)));
      check("sync_byte_start", 32'(byte_start), 32'((n % 8) == 0));
      check("sync_sym", 32'(sym_is_data), 32'(0));
      check("sync_ready", 32'(ready_out), 32'(n >= 32));
    end

    // Single byte A5 presented at edge 33.
    valid_in = 1'b1; data_in = 8'hA5;
    tick();
    check("a5_ready_after_xfer", 32'(ready_out), 32'(0));
    valid_in = 1'b0; data_in = 8'h00;
    run_to(39);
    check("a5_sym_before", 32'(sym_is_data), 32'(0));
    for (int n = 40; n <= 47; n++) begin
      tick();
      check("a5_sym", 32'(sym_is_data), 32'(1));
      check("a5_bit", 32'(data_out), 32'(bit_of(8'hA5, n)));
      if (n == 40) check("a5_ready_rise", 32'(ready_out), 32'(1));
    end
    tick();
    check("a5_idle_after", 32'(sym_is_data), 32'(0));

    // Transfer exactly on the boundary edge 56: idle for that symbol, byte next.
    run_to(55);
    valid_in = 1'b1; data_in = 8'h3C;
    tick();
    check("bnd_sym", 32'(sym_is_data), 32'(0));
    check("bnd_data_out", 32'(data_out), 32'(1));
    check("bnd_ready", 32'(ready_out), 32'(0));
    valid_in = 1'b0; data_in = 8'h00;
    for (int n = 57; n <= 71; n++) begin
      tick();
      if (n < 64) begin
        check("bnd_idle_bit", 32'(data_out), 32'(bit_of(IDLE, n)));
      end else begin
        check("bnd_3c_sym", 32'(sym_is_data), 32'(1));
        check("bnd_3c_bit", 32'(data_out), 32'(bit_of(8'h3C, n)));
      end
    end

    // Back-to-back bytes 01,02,03 with valid_in held high (transfers at 33,41,49).
    do_reset();
    run_to(32);
    valid_in = 1'b1; data_in = seq[0];
    tick();
    data_in = seq[1];
    run_to(41);
    data_in = seq[2];
    run_to(49);
    valid_in = 1'b0; data_in = 8'h00;
    run_to(39);
    for (int n = 50; n <= 71; n++) begin
      tick();
    end
    // Replay the same stimulus and sample the symbols this time.
    do_reset();
    run_to(32);
    valid_in = 1'b1; data_in = seq[0];
    for (int n = 33; n <= 71; n++) begin
      tick();
      if (n == 33) data_in = seq[1];
      if (n == 41) data_in = seq[2];
      if (n == 49) begin valid_in = 1'b0; data_in = 8'h00; end
      if (n >= 40 && n <= 63) begin
        check("b2b_sym", 32'(sym_is_data), 32'(1));
        check("b2b_bit", 32'(data_out), 32'(bit_of(seq[(n - 40) / 8], n)));
      end else if (n >= 64) begin
        check("b2b_idle_sym", 32'(sym_is_data), 32'(0));
        check("b2b_idle_bit", 32'(data_out), 32'(bit_of(IDLE, n)));
      end
    end

    // valid_in high throughout sync: nothing accepted before edge 33.
    do_reset();
    valid_in = 1'b1; data_in = 8'hC3;
    for (int n = 1; n <= 47; n++) begin
      tick();
      if (n == 33) begin valid_in = 1'b0; data_in = 8'h00; end
      if (n < 40) begin
        check("vsync_sym", 32'(sym_is_data), 32'(0));
        check("vsync_bit", 32'(data_out), 32'(bit_of(IDLE, n)));
        if (n <= 31) check("vsync_ready", 32'(ready_out), 32'(0));
      end else begin
        check("vsync_c3_bit", 32'(data_out), 32'(bit_of(8'hC3, n)));
      end
    end

    // Reset mid-symbol with A5 in shreg and 5A in hold: both discarded.
    do_reset();
    run_to(32);
    valid_in = 1'b1; data_in = 8'hA5;
    tick();
    data_in = 8'h5A;
    run_to(41);
    valid_in = 1'b0; data_in = 8'h00;
    run_to(43);
    check("mid_sym_before_rst", 32'(sym_is_data), 32'(1));
    check("mid_ready_before_rst", 32'(ready_out), 32'(0));
    reset = 1'b1;
    #1;
    check_reset_outs();
    @(negedge clk_32f);
    reset  = 1'b0;
    edge_n = 0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      check("post_rst_sym", 32'(sym_is_data), 32'(0));
      check("post_rst_bit", 32'(data_out), 32'(bit_of(IDLE, n)));
      check("post_rst_ready", 32'(ready_out), 32'(n >= 32));
    end

    // SYNC_CNT=1 instance: ready after edge 8, byte taken at edge 9, sent from 16.
    @(negedge clk_32f);
    valid_in1 = 1'b1; data_in1 = 8'h96;
    #1;
    check("s1_rst_ready", 32'(ready_out1), 32'(0));
    check("s1_rst_data_out", 32'(data_out1), 32'(1));
    @(negedge clk_32f);
    reset1 = 1'b0;
    edge_n = 0;
    for (int n = 1; n <= 23; n++) begin
      tick();
      if (n == 9) begin valid_in1 = 1'b0; data_in1 = 8'h00; end
      if (n <= 7) check("s1_ready_low", 32'(ready_out1), 32'(0));
      if (n == 8) check("s1_ready_rise", 32'(ready_out1), 32'(1));
      if (n == 9) check("s1_ready_after_xfer", 32'(ready_out1), 32'(0));
      if (n < 16) begin
        check("s1_sym_idle", 32'(sym_is_data1), 32'(0));
        check("s1_idle_bit", 32'(data_out1), 32'(bit_of(IDLE, n)));
      end else begin
        check("s1_sym_data", 32'(sym_is_data1), 32'(1));
        check("s1_96_bit", 32'(data_out1), 32'(bit_of(8'h96, n)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
